// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes and LSU state encoding.
package riscv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering, load extraction/extension and legality check.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        illegal
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{offset, 3'b000} +: 8];
        half_sel   = rdata[{offset[1], 4'b0000} +: 16];
        be         = '0;
        wdata_lane = '0;
        load_data  = '0;
        illegal    = 1'b1;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h0, byte_sel};
                illegal    = (funct3 == F3_BU) & is_store;
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
                illegal    = offset[0] | ((funct3 == F3_HU) & is_store);
            end
            F3_W: begin
                be         = '1;
                wdata_lane = wdata;
                load_data  = rdata;
                illegal    = |offset;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: data-bus handshake FSM with timeout, core stall and error reporting.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             store_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             err_q;
    logic [31:0]      load_q;

    logic             in_idle;
    logic             timed_out;
    logic             a_store;
    logic [2:0]       a_f3;
    logic [1:0]       a_off;
    logic [3:0]       a_be;
    logic [31:0]      a_wdata;
    logic [31:0]      a_load;
    logic             a_illegal;

    // One aligner serves both phases: live inputs in IDLE, latched fields afterwards.
    assign in_idle = (state == IDLE);
    assign a_store = in_idle ? is_store  : store_q;
    assign a_f3    = in_idle ? funct3    : f3_q;
    assign a_off   = in_idle ? addr[1:0] : off_q;

    lsu_align u_align (
        .funct3     (a_f3),
        .is_store   (a_store),
        .offset     (a_off),
        .wdata      (wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_lane (a_wdata),
        .load_data  (a_load),
        .illegal    (a_illegal)
    );

    // >= rather than == so a grant on the final REQ cycle still bounds WAIT.
    assign timed_out = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    assign stall     = (in_idle & start) | (state == REQ) | (state == WAIT);
    assign done      = (state == DONE);
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) & store_q;
    assign err       = err_q;
    assign load_data = load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            store_q   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            err_q     <= 1'b0;
            load_q    <= '0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        store_q   <= is_store;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= a_be;
                        mem_wdata <= a_wdata;
                        cnt       <= '0;
                        err_q     <= a_illegal;
                        state     <= a_illegal ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (store_q) begin
                            state <= DONE;
                        end else if (mem_rvalid) begin
                            load_q <= a_load;
                            state  <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= WAIT;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        load_q <= a_load;
                        state  <= DONE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_q  <= 1'b0;
                    load_q <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the ALU. Takes the ALU result as the effective address for RV32I loads and stores.
- Runs the data-memory bus handshake and stalls the single-cycle core while an access is outstanding.
- Steers store data onto byte lanes and returns sign- or zero-extended load data for register writeback.
- Flags misaligned accesses, illegal widths and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, number of cycles in REQ+WAIT before the access is abandoned with err.
- CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  current instruction is a load/store; held high by the core while stall=1.
- is_store  input  1  1=store, 0=load; valid with start.
- funct3  input  3  RV32I width/sign field.
- addr  input  32  effective address (ALU result).
- wdata  input  32  store data (rs2).
- stall  output  1  freeze PC/pipeline.
- done  output  1  one-cycle pulse: access finished; load_data/err valid this cycle.
- load_data  output  32  extended load result, valid with done on loads.
- err  output  1  valid with done: misaligned, illegal funct3 or timeout.
- mem_req  output  1  bus request.
- mem_we  output  1  write enable.
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-steered store data.
- mem_gnt  input  1  bus accepted the request this cycle.
- mem_rvalid  input  1  read data valid (loads only).
- mem_rdata  input  32  read data word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state=IDLE, counter=0, all outputs 0, registered request fields cleared.
- Reset mid-access: mem_req drops immediately (asynchronous). Any later mem_gnt or mem_rvalid is ignored.
- IDLE + start:
  - Latch is_store, funct3, addr[1:0], mem_addr, mem_be, mem_wdata.
  - If the access is legal, go to REQ. Otherwise go to DONE with err=1 and issue no bus request.
- funct3 encoding: 000=B, 001=H, 010=W, 100=BU, 101=HU.
- Illegal cases:
  - funct3 011, 110 or 111 on either loads or stores.
  - BU or HU on a store.
  - H or HU with addr[0]=1.
  - W with addr[1:0]!=0.
- REQ: mem_req=1 with stable fields.
  - Store + gnt: go to DONE.
  - Load + gnt: go to WAIT; mem_req drops the next cycle.
  - Load + gnt + rvalid in the same cycle: capture rdata and go to DONE.
- WAIT: on rvalid, capture mem_rdata and go to DONE.
- Timeout:
  - The counter clears on leaving IDLE and increments every REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no gnt/rvalid, go to DONE with err=1.
- DONE: done=1, stall=0, start ignored. Next state is IDLE.
- stall is combinational: (IDLE & start) | REQ | WAIT. The core therefore stalls from the first cycle of the instruction.
- Minimum latency:
  - Store: 2 stall cycles (IDLE, REQ), then the done cycle.
  - Load with single-cycle rvalid: 3 stall cycles.
- Byte enables by width:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- mem_wdata: byte replicated ×4 or half replicated ×2; word stored unchanged.
- load_data extraction:
  - Byte lane = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - B and H sign-extend; BU and HU zero-extend.
- Data-valid rules:
  - load_data is 0 when no load completes or when err=1.
  - mem_we=0 except during REQ of a store.
  - err=0 except in DONE.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load/store constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum: IDLE/REQ/WAIT/DONE.
- One combinational sub-module lsu_align:
  - Inputs: funct3, offset, wdata, rdata.
  - Outputs: be, steered wdata, extended load_data, misaligned/illegal flag.
- FSM, counter and bus registers stay in load_store_unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on the first REQ cycle -> mem_addr=0x100, be=4'b1111, mem_wdata=0xDEADBEEF, we=1; done after exactly 2 stall cycles; err=0.
- SB addr=0x103, wdata=0x000000A5 -> be=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB and LBU addr=0x102, rdata=0x1280FF34 -> load_data 0xFFFFFF80 and 0x00000080 respectively.
- LH addr=0x101 -> no mem_req ever asserted; done and err=1 the cycle after start. LW addr=0x102 -> same result.
- LW with gnt never asserted, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then done with err=1 and load_data=0. A late rvalid in IDLE changes nothing.
- rst asserted during WAIT -> mem_req, stall and done go low immediately; state returns to IDLE. A new LW issued after reset completes normally.
